// File: rtl/uart_tx.sv
// Memory-mapped UART transmitter: byte FIFO fed by bus writes, 8N1 serialiser,
// registered status word with sticky overflow.
`ifndef IO_MEM_MAP_BIT
`define IO_MEM_MAP_BIT 22
`endif
`ifndef UART_MEM_MAP_BIT
`define UART_MEM_MAP_BIT 3
`endif

module uart_tx #(
    parameter int IO_MEM_MAP_BIT   = `IO_MEM_MAP_BIT,
    parameter int UART_MEM_MAP_BIT = `UART_MEM_MAP_BIT,
    parameter int CLKS_PER_BIT     = 868,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_rstrb_i,
    output logic [31:0] mem_rdata_o,
    input  logic [3:0]  mem_wmask_i,
    input  logic [31:0] mem_wdata_i,
    output logic        tx_o,
    output logic        busy_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_reg, state_next;
    logic [BAUD_W-1:0] baud_reg, baud_next;
    logic [2:0]        bit_reg, bit_next;
    logic [7:0]        shift_reg, shift_next;
    logic              tx_reg, tx_next;
    logic [31:0]       rdata_reg;
    logic              ovf_reg;
    logic [PTR_W:0]    wr_ptr_reg, rd_ptr_reg;
    logic [7:0]        fifo_mem [FIFO_DEPTH];

    logic access, wr, rd, push, pop, full, empty, ovf_set, busy;
    logic [31:0] status;
    logic unused_bits;

    assign unused_bits = ^{mem_addr_i, mem_wmask_i[3:1], mem_wdata_i[31:8]};

    assign access = mem_addr_i[IO_MEM_MAP_BIT] & mem_addr_i[UART_MEM_MAP_BIT];
    assign wr     = access & mem_wmask_i[0];
    assign rd     = access & mem_rstrb_i;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg == (rd_ptr_reg ^ {1'b1, {PTR_W{1'b0}}}));
    assign push    = wr & (~full | pop);
    assign ovf_set = wr & full & ~pop;
    assign busy    = ~empty | (state_reg != IDLE);
    assign status  = {28'd0, ovf_reg, busy, empty, full};

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        pop        = 1'b0;
        tx_next    = 1'b1;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_mem[rd_ptr_reg[PTR_W-1:0]];
                    baud_next  = BAUD_RELOAD;
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (baud_reg == '0) begin
                    baud_next  = BAUD_RELOAD;
                    bit_next   = 3'd0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg - BAUD_W'(1);
                end
            end
            DATA: begin
                tx_next = shift_reg[0];
                if (baud_reg == '0) begin
                    baud_next  = BAUD_RELOAD;
                    shift_next = {1'b0, shift_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7)
                        state_next = STOP;
                end else begin
                    baud_next = baud_reg - BAUD_W'(1);
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (baud_reg == '0) begin
                    // Chain straight into the next start bit when more data is queued.
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_mem[rd_ptr_reg[PTR_W-1:0]];
                        baud_next  = BAUD_RELOAD;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_reg - BAUD_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            baud_reg   <= '0;
            bit_reg    <= 3'd0;
            shift_reg  <= 8'd0;
            tx_reg     <= 1'b1;
            rdata_reg  <= 32'd0;
            ovf_reg    <= 1'b0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
            rdata_reg <= rd ? status : 32'd0;
            // A read clears overflow unless the same cycle overflows again.
            ovf_reg   <= rd ? ovf_set : (ovf_reg | ovf_set);
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= mem_wdata_i[7:0];
    end

    assign tx_o        = tx_reg;
    assign busy_o      = busy;
    assign mem_rdata_o = rdata_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a cycle-level occupancy/schedule model predicts
// frames and status words; a monitor decodes the serial line and compares.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int IOB   = 22;
    localparam int UB    = 3;
    localparam logic [31:0] VALID_ADDR = (32'd1 << IOB) | (32'd1 << UB);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic        mem_rstrb_i = 1'b0;
    logic [31:0] mem_rdata_o;
    logic [3:0]  mem_wmask_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic        tx_o;
    logic        busy_o;

    uart_tx #(
        .IO_MEM_MAP_BIT(IOB), .UART_MEM_MAP_BIT(UB),
        .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .mem_addr_i(mem_addr_i), .mem_rstrb_i(mem_rstrb_i),
        .mem_rdata_o(mem_rdata_o), .mem_wmask_i(mem_wmask_i), .mem_wdata_i(mem_wdata_i),
        .tx_o(tx_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] b; int unsigned start; } frame_t;
    typedef struct { logic [31:0] rdata; logic busy; } stat_t;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: FIFO as a queue, transmitter as "busy until start + 10 bit-times".
    logic [7:0]  fifo_q[$];
    frame_t      exp_q[$];
    stat_t       stat_q[$];
    int unsigned cyc = 0;
    int unsigned next_free = 0;
    logic        ovf_m = 1'b0;
    logic        busy_m = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_q.delete(); exp_q.delete(); stat_q.delete();
            next_free = 0; ovf_m = 1'b0; busy_m = 1'b0;
        end else begin
            logic acc, w, r, fl, pp, oset;
            logic [31:0] st;
            stat_t s;
            cyc++;
            acc  = mem_addr_i[IOB] && mem_addr_i[UB];
            w    = acc && mem_wmask_i[0];
            r    = acc && mem_rstrb_i;
            fl   = (fifo_q.size() == DEPTH);
            st   = {28'd0, ovf_m, busy_m, fifo_q.size() == 0, fl};
            pp   = (cyc >= next_free) && (fifo_q.size() > 0);
            oset = w && fl && !pp;
            if (pp) begin
                frame_t f;
                f.b = fifo_q.pop_front();
                f.start = cyc + 1;
                exp_q.push_back(f);
                next_free = cyc + 10 * CPB;
            end
            if (w && (!fl || pp)) fifo_q.push_back(mem_wdata_i[7:0]);
            ovf_m  = r ? oset : (ovf_m | oset);
            busy_m = (fifo_q.size() > 0) || (cyc < next_free);
            s.rdata = r ? st : 32'd0;
            s.busy  = busy_m;
            stat_q.push_back(s);
        end
    end

    // Monitor: status/busy scoreboard plus a mid-bit sampling serial receiver.
    logic        rx_active = 1'b0;
    int unsigned rx_start = 0;
    logic [7:0]  rx_byte = '0;

    always @(negedge clk) begin
        if (!rst) begin
            rx_active = 1'b0;
            chk("reset_tx", {31'd0, tx_o}, 32'd1);
            chk("reset_busy", {31'd0, busy_o}, 32'd0);
            chk("reset_rdata", mem_rdata_o, 32'd0);
        end else begin
            if (stat_q.size() > 0) begin
                stat_t s;
                s = stat_q.pop_front();
                chk("rdata", mem_rdata_o, s.rdata);
                chk("busy", {31'd0, busy_o}, {31'd0, s.busy});
            end
            if (!rx_active) begin
                if (tx_o == 1'b0) begin
                    rx_active = 1'b1;
                    rx_start  = cyc;
                    rx_byte   = '0;
                    chk("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) chk("frame_start_cycle", cyc, exp_q[0].start);
                end
            end else begin
                int off, idx;
                off = int'(cyc - rx_start);
                if (off % CPB == CPB / 2) begin
                    idx = off / CPB;
                    if (idx == 0) chk("start_bit", {31'd0, tx_o}, 32'd0);
                    else if (idx <= 8) rx_byte[idx-1] = tx_o;
                    else begin
                        frame_t f;
                        chk("stop_bit", {31'd0, tx_o}, 32'd1);
                        if (exp_q.size() != 0) begin
                            f = exp_q.pop_front();
                            $display("frame rx 0x%02h expected 0x%02h at cycle %0d", rx_byte, f.b, rx_start);
                            chk("frame_byte", {24'd0, rx_byte}, {24'd0, f.b});
                        end
                        rx_active = 1'b0;
                    end
                end
            end
        end
    end

    // Stimulus: every task is entered 2ns after a rising edge and returns likewise.
    task automatic bus_cycle(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d, input logic r);
        mem_addr_i = a; mem_wmask_i = m; mem_wdata_i = d; mem_rstrb_i = r;
        @(posedge clk); #2;
        mem_addr_i = '0; mem_wmask_i = '0; mem_wdata_i = '0; mem_rstrb_i = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        bus_cycle(VALID_ADDR, 4'b0001, {24'd0, b}, 1'b0);
    endtask

    task automatic rd_status();
        bus_cycle(VALID_ADDR, 4'b0000, 32'd0, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int n;
        @(posedge clk); #2;
        idle(3);
        rst = 1'b1;
        idle(2);

        rd_status();
        chk("status_after_reset", mem_rdata_o, 32'h2);

        wr_byte(8'h55);
        idle(50);
        chk("single_frame_idle", {31'd0, busy_o}, 32'd0);

        for (int i = 1; i <= 6; i++) wr_byte(8'(i));
        rd_status();
        chk("status_overflow", mem_rdata_o, 32'hD);
        rd_status();
        chk("overflow_cleared", {31'd0, mem_rdata_o[3]}, 32'd0);
        idle(220);

        bus_cycle(32'd1 << IOB, 4'b0001, 32'hA5, 1'b0);
        bus_cycle(VALID_ADDR, 4'b1110, 32'h5A, 1'b0);
        idle(20);
        rd_status();
        chk("ignored_writes_status", mem_rdata_o, 32'h2);
        chk("ignored_writes_tx", {31'd0, tx_o}, 32'd1);

        wr_byte(8'hA1); wr_byte(8'hA2); wr_byte(8'hA3);
        idle(19);
        rst = 1'b0;
        #1;
        chk("async_reset_tx", {31'd0, tx_o}, 32'd1);
        #1;
        idle(3);
        rst = 1'b1;
        idle(1);
        rd_status();
        chk("status_after_midframe_reset", mem_rdata_o, 32'h2);
        idle(60);

        for (int i = 0; i < 5; i++) wr_byte(8'hC0 + 8'(i));
        idle(35);
        rd_status();
        chk("full_before_pop", {31'd0, mem_rdata_o[0]}, 32'd1);
        wr_byte(8'h77);
        rd_status();
        chk("full_write_with_pop", mem_rdata_o, 32'h5);
        idle(250);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) != 0) ? VALID_ADDR : ($urandom & ~VALID_ADDR);
            bus_cycle(a, 4'($urandom), $urandom, $urandom_range(0, 3) == 0);
        end

        n = 0;
        while ((exp_q.size() != 0 || rx_active || busy_o) && n < 3000) begin
            @(posedge clk); n++;
        end
        #2;
        chk("drain_in_time", {31'd0, n < 3000}, 32'd1);
        idle(2);
        chk("final_tx_idle", {31'd0, tx_o}, 32'd1);
        chk("final_pending", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter IO_MEM_MAP_BIT, default `IO_MEM_MAP_BIT, address bit that selects the IO region.
REQ-002 Parameter UART_MEM_MAP_BIT, default `UART_MEM_MAP_BIT, address bit that selects the UART within the IO region.
REQ-003 Parameter CLKS_PER_BIT, default 868, clk cycles per serial bit; legal values are 2 and above.
REQ-004 Parameter FIFO_DEPTH, default 4, transmit FIFO entries; legal values are powers of two, 2 and above.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 mem_addr_i  input  32  bus address.
REQ-008 mem_rstrb_i  input  1  read strobe.
REQ-009 mem_rdata_o  output  32  registered status word.
REQ-010 mem_wmask_i  input  4  byte write mask; only bit 0 is used.
REQ-011 mem_wdata_i  input  32  write data; only bits [7:0] are used.
REQ-012 tx_o  output  1  serial line, registered, idle high.
REQ-013 busy_o  output  1  high while the FIFO is non-empty or a frame is in progress.

Function
REQ-014 Access is asserted when mem_addr_i[IO_MEM_MAP_BIT] and mem_addr_i[UART_MEM_MAP_BIT] are both 1; all other addresses shall have no effect.
REQ-015 A write (access and mem_wmask_i[0]) shall push mem_wdata_i[7:0] into the FIFO when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-016 A write to a full FIFO with no same-cycle pop shall be dropped and shall set the sticky overflow flag.
REQ-017 Status word layout: bit0 = FIFO full; bit1 = FIFO empty; bit2 = busy_o; bit3 = overflow; bits [31:4] = 0.
REQ-018 Read (access and mem_rstrb_i): mem_rdata_o shall present the status word sampled at that edge from the next cycle onward; otherwise mem_rdata_o shall be 0 in the following cycle.
REQ-019 A read shall clear overflow after sampling; if an overflowing write occurs in the same cycle as the read, overflow shall remain set.
REQ-020 Transmit FSM states: IDLE, START, DATA, STOP.
REQ-021 IDLE with FIFO non-empty: pop one byte into the shift register, go to START; tx_o is driven 0 from the next edge.
REQ-022 Each of START, each DATA bit and STOP shall hold tx_o for exactly CLKS_PER_BIT cycles; the baud counter reloads at every bit boundary.
REQ-023 DATA shall send 8 bits LSB first, then go to STOP with tx_o = 1.
REQ-024 At the end of STOP: if the FIFO is non-empty, pop and enter START directly, with no idle bit between frames; otherwise enter IDLE.
REQ-025 A frame shall be 10 bit-times: 1 start, 8 data, 1 stop; no parity.
REQ-026 FIFO read and write pointers shall wrap modulo FIFO_DEPTH; full and empty shall be exact at every occupancy from 0 to FIFO_DEPTH.
REQ-027 Simultaneous push and pop on a non-full, non-empty FIFO shall leave occupancy unchanged.

Reset
REQ-028 On rst low, immediately and without waiting for clk: tx_o = 1, busy_o = 0, mem_rdata_o = 0, state = IDLE, FIFO empty, overflow = 0, baud counter = 0.
REQ-029 Reset asserted mid-frame shall abort the frame, with no partial-byte resumption after release.
REQ-030 Reset release shall take effect on the first rising clk edge with rst high.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-031 Reset, then read status -> mem_rdata_o = 0x00000002, tx_o = 1, busy_o = 0.
REQ-032 Single write of 0x55 -> tx_o falls 2 edges after the write edge; line carries 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; busy_o drops after 40 cycles of frame.
REQ-033 Writes 0x01..0x06 on 6 consecutive cycles -> bytes 0x01..0x05 are sent back-to-back (200 cycles, no idle gap); 0x06 is never sent; status read = 0x0000000D before draining; a second read shows bit3 = 0.
REQ-034 Write with mem_addr_i[UART_MEM_MAP_BIT] = 0, or with mem_wmask_i = 4'b1110 -> no FIFO change and tx_o stays 1.
REQ-035 Assert rst during bit 3 of a frame with 2 bytes queued -> tx_o = 1 at once; after release, status = 0x00000002 and no further frame is sent.
REQ-036 Write when full in the same cycle the FSM pops (end of STOP) -> byte accepted, overflow stays 0.
